// File: rtl/milano_pkg.sv
// Shared milano core definitions: architectural register file geometry and basic data types.
package milano_pkg;

    localparam int REG_NUM = 32;
    localparam int REG_AW  = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [31:0]       xlen_t;

endpackage : milano_pkg

// File: rtl/regs_sb.sv
// Busy scoreboard for the integer register file: one busy bit per register, set on issue, cleared on writeback or flush.
// Build option REGS_FILE_BYPASS_EN lets a same-cycle writeback mask the busy bit it is about to clear.
module regs_sb
    import milano_pkg::*;
#(
    parameter  int NREG = REG_NUM,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREG-1:0] wr_hit,
    input  logic            issue_valid_i,
    input  logic [AW-1:0]   issue_rd_i,
    input  logic            flush_i,
    output logic [NREG-1:0] busy_eff,
    output logic            issue_ready_o
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic [NREG-1:0] issue_set_s;
    logic            issue_acc_s;

    // Busy as seen by ID this cycle
    always_comb begin
`ifdef REGS_FILE_BYPASS_EN
        busy_eff = busy_r & ~wr_hit;
`else
        busy_eff = busy_r;
`endif
    end

    // Issue handshake; x0 never stalls and is never marked busy
    always_comb begin
        issue_ready_o = !issue_valid_i || (issue_rd_i == {AW{1'b0}}) || !busy_eff[issue_rd_i];
        issue_acc_s   = issue_valid_i && issue_ready_o && (issue_rd_i != {AW{1'b0}});
        issue_set_s   = {{(NREG-1){1'b0}}, issue_acc_s} << issue_rd_i;
    end

    // Next busy vector: flush beats everything, a new producer beats its own register's writeback
    always_comb begin
        busy_nxt_s = {NREG{1'b0}};
        if (flush_i) begin
            busy_nxt_s = {NREG{1'b0}};
        end else begin
            busy_nxt_s = (busy_r & ~wr_hit) | issue_set_s;
        end
    end

    // Busy vector state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

endmodule : regs_sb

// File: rtl/regs_file_sb.sv
// Parametrised integer register file with NRD combinational read ports, NWR write ports and a RAW/WAW scoreboard.
// Build option REGS_FILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regs_file_sb
    import milano_pkg::*;
#(
    parameter  int XLEN = $bits(xlen_t),
    parameter  int NREG = REG_NUM,
    parameter  int NRD  = 2,
    parameter  int NWR  = 1,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NRD-1:0][AW-1:0]   raddr_i,
    output logic [NRD-1:0][XLEN-1:0] rdata_o,
    output logic [NRD-1:0]           rbusy_o,
    input  logic [NWR-1:0]           we_i,
    input  logic [NWR-1:0][AW-1:0]   waddr_i,
    input  logic [NWR-1:0][XLEN-1:0] wdata_i,
    input  logic                     issue_valid_i,
    input  logic [AW-1:0]            issue_rd_i,
    output logic                     issue_ready_o,
    input  logic                     flush_i
);

    logic [XLEN-1:0] regs_r    [NREG];
    logic [XLEN-1:0] wr_data_s [NREG];
    logic [NREG-1:0] wr_hit_s;
    logic [NREG-1:0] busy_eff_s;
    logic            port_hit_s;

    // Per-register write resolution; later ports overwrite earlier ones, x0 never hit
    always_comb begin
        wr_hit_s   = {NREG{1'b0}};
        port_hit_s = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            wr_data_s[r] = {XLEN{1'b0}};
        end
        for (int r = 1; r < NREG; r++) begin
            for (int w = 0; w < NWR; w++) begin
                port_hit_s   = we_i[w] && (waddr_i[w] == AW'(r));
                wr_hit_s[r]  = wr_hit_s[r] | port_hit_s;
                wr_data_s[r] = port_hit_s ? wdata_i[w] : wr_data_s[r];
            end
        end
    end

    // Data array
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= {XLEN{1'b0}};
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wr_hit_s[r]) begin
                    regs_r[r] <= wr_data_s[r];
                end
            end
        end
    end

    // Read muxes and per-port hazard flags
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
`ifdef REGS_FILE_BYPASS_EN
            rdata_o[p] = (raddr_i[p] == {AW{1'b0}}) ? {XLEN{1'b0}} :
                         wr_hit_s[raddr_i[p]]       ? wr_data_s[raddr_i[p]] :
                                                      regs_r[raddr_i[p]];
`else
            rdata_o[p] = (raddr_i[p] == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[raddr_i[p]];
`endif
            rbusy_o[p] = busy_eff_s[raddr_i[p]] && (raddr_i[p] != {AW{1'b0}});
        end
    end

    regs_sb #(
        .NREG (NREG)
    ) u_sb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_hit        (wr_hit_s),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .flush_i       (flush_i),
        .busy_eff      (busy_eff_s),
        .issue_ready_o (issue_ready_o)
    );

endmodule : regs_file_sb

// File: tb/tb_regs_file_sb.sv
// Self-checking bench for regs_file_sb (NRD=2, NWR=2): directed scenarios plus randomized traffic against an array model.
module tb_regs_file_sb;

`ifdef REGS_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][4:0]  raddr;
    logic [1:0][31:0] rdata;
    logic [1:0]       rbusy;
    logic [1:0]       we;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic             iv;
    logic [4:0]       ird;
    logic             ready;
    logic             flush;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: register contents, busy bits, and this cycle's resolved writes
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_ok = 1'b0;
    bit          w_hit  [32];
    logic [31:0] w_val  [32];
    bit          last_acc;

    regs_file_sb #(.NRD(2), .NWR(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .raddr_i       (raddr),
        .rdata_o       (rdata),
        .rbusy_o       (rbusy),
        .we_i          (we),
        .waddr_i       (waddr),
        .wdata_i       (wdata),
        .issue_valid_i (iv),
        .issue_rd_i    (ird),
        .issue_ready_o (ready),
        .flush_i       (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic calc_writes();
        for (int a = 0; a < 32; a++) begin
            w_hit[a] = 1'b0;
            w_val[a] = 32'h0;
        end
        for (int w = 0; w < 2; w++) begin
            if (we[w] && waddr[w] != 5'd0) begin
                w_hit[waddr[w]] = 1'b1;
                w_val[waddr[w]] = wdata[w];
            end
        end
    endtask

    function automatic bit eff_busy(input logic [4:0] a);
        return m_busy[a] && !(BYP && w_hit[a]);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYP && w_hit[a]) return w_val[a];
        return m_regs[a];
    endfunction

    function automatic bit exp_ready();
        return !iv || ird == 5'd0 || !eff_busy(ird);
    endfunction

    task automatic compare();
        calc_writes();
        if (m_ok) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rdata%0d", p), rdata[p], exp_rdata(raddr[p]));
                chk($sformatf("rbusy%0d", p), {31'd0, rbusy[p]},
                    {31'd0, eff_busy(raddr[p]) && raddr[p] != 5'd0});
            end
            chk("issue_ready", {31'd0, ready}, {31'd0, exp_ready()});
        end
    endtask

    task automatic update_model();
        bit acc;
        calc_writes();
        acc = iv && exp_ready() && ird != 5'd0;
        last_acc = iv && exp_ready();
        if (rst) begin
            for (int a = 0; a < 32; a++) begin
                m_regs[a] = 32'h0;
                m_busy[a] = 1'b0;
            end
            m_ok = 1'b1;
        end else begin
            for (int a = 1; a < 32; a++) begin
                if (w_hit[a]) m_regs[a] = w_val[a];
                if (flush) m_busy[a] = 1'b0;
                else if (acc && ird == a[4:0]) m_busy[a] = 1'b1;
                else if (w_hit[a]) m_busy[a] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        #1 compare();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; iv = 1'b0; ird = 5'd0;
        we = 2'b00; waddr = '{5'd0, 5'd0}; wdata = '{32'h0, 32'h0};
        raddr = '{5'd0, 5'd0};
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        bit hold;
        logic [4:0] hold_rd;
        idle();
        @(negedge clk);

        // Reset, then read {5,0}
        rst = 1'b1; cycle(); cycle();
        rst = 1'b0; raddr[0] = 5'd5; raddr[1] = 5'd0;
        #1 chk("rst_rdata0", rdata[0], 32'h0); chk("rst_rdata1", rdata[1], 32'h0);
        chk("rst_rbusy", {30'd0, rbusy}, 32'h0); chk("rst_ready", {31'd0, ready}, 32'h1);
        cycle();

        // Write r3, read it back
        we[0] = 1'b1; waddr[0] = 5'd3; wdata[0] = 32'hDEADBEEF; cycle();
        idle(); raddr[0] = 5'd3;
        #1 chk("wr_r3", rdata[0], 32'hDEADBEEF);
        cycle();

        // x0: writes ignored, issue to x0 never marks busy
        we[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'h1234; cycle();
        idle(); raddr[0] = 5'd0; iv = 1'b1; ird = 5'd0;
        #1 chk("x0_rdata", rdata[0], 32'h0); chk("x0_ready", {31'd0, ready}, 32'h1);
        cycle();
        #1 chk("x0_rbusy", {31'd0, rbusy[0]}, 32'h0); chk("x0_ready2", {31'd0, ready}, 32'h1);
        cycle();

        // RAW on r7
        idle(); iv = 1'b1; ird = 5'd7;
        #1 chk("raw_issue_ready", {31'd0, ready}, 32'h1);
        cycle();
        idle(); raddr[0] = 5'd7;
        #1 chk("raw_rbusy", {31'd0, rbusy[0]}, 32'h1);
        cycle();
        we[0] = 1'b1; waddr[0] = 5'd7; wdata[0] = 32'h55;
`ifdef REGS_FILE_BYPASS_EN
        #1 chk("raw_wb_rbusy", {31'd0, rbusy[0]}, 32'h0); chk("raw_wb_rdata", rdata[0], 32'h55);
`else
        #1 chk("raw_wb_rbusy", {31'd0, rbusy[0]}, 32'h1); chk("raw_wb_rdata", rdata[0], 32'h0);
`endif
        cycle();
        idle(); raddr[0] = 5'd7;
        #1 chk("raw_after_rbusy", {31'd0, rbusy[0]}, 32'h0); chk("raw_after_rdata", rdata[0], 32'h55);
        cycle();

        // WAW on r9, then flush
        idle(); iv = 1'b1; ird = 5'd9; cycle();
        #1 chk("waw_ready", {31'd0, ready}, 32'h0);
        cycle();
        iv = 1'b0; flush = 1'b1; cycle();
        flush = 1'b0; iv = 1'b1; ird = 5'd9; raddr[0] = 5'd9;
        #1 chk("flush_ready", {31'd0, ready}, 32'h1); chk("flush_rbusy", {31'd0, rbusy[0]}, 32'h0);
        cycle();
        idle(); flush = 1'b1; cycle();

        // Two ports write r4: port 1 wins; then issue r4 alongside its write
        idle(); we = 2'b11; waddr[0] = 5'd4; waddr[1] = 5'd4; wdata[0] = 32'hA; wdata[1] = 32'hB; cycle();
        idle(); raddr[0] = 5'd4;
        #1 chk("coll_r4", rdata[0], 32'hB);
        cycle();
        we[0] = 1'b1; waddr[0] = 5'd4; wdata[0] = 32'hC; iv = 1'b1; ird = 5'd4;
        #1 chk("coll_issue_ready", {31'd0, ready}, 32'h1);
        cycle();
        idle(); raddr[0] = 5'd4;
        #1 chk("coll_busy", {31'd0, rbusy[0]}, 32'h1); chk("coll_data", rdata[0], 32'hC);
        cycle();

        // Randomized traffic; a stalled issue is held stable as ID would
        hold = 1'b0; hold_rd = 5'd0;
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 15) == 0);
            for (int w = 0; w < 2; w++) begin
                we[w]    = 1'($urandom_range(0, 1));
                waddr[w] = pick();
                wdata[w] = $urandom();
            end
            raddr[0] = pick(); raddr[1] = pick();
            if (hold) begin
                iv = 1'b1; ird = hold_rd;
            end else begin
                iv = 1'($urandom_range(0, 1)); ird = pick();
            end
            cycle();
            hold = iv && !last_acc && !flush && !rst;
            hold_rd = ird;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regs_file_sb

// File: doc/regs_file_sb.md
Name: regs_file_sb

Overview:
- Parametrised successor to the integer register file for the milano core.
- Provides NRD combinational read ports and NWR synchronous write ports, plus a per-register busy scoreboard for hazard detection.
- The ID stage uses the scoreboard to stall on RAW hazards and to hold issue on WAW hazards.
- Sits inside id_stage. Read ports serve the decoder; write ports are driven from the EX/WB writeback paths; issue and flush come from ID/ctrl.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2. Higher port index has priority.
- AW, $clog2(NREG), register address width; derived, not overridden.

Ports:
- clk_i  in  1  clock. One clock only; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- raddr_i  in  NRD*AW  read addresses, packed [NRD-1:0][AW-1:0].
- rdata_o  out  NRD*XLEN  read data.
- rbusy_o  out  NRD  hazard flag per read port: operand not yet valid.
- we_i  in  NWR  write enables.
- waddr_i  in  NWR*AW  write addresses.
- wdata_i  in  NWR*XLEN  write data.
- issue_valid_i  in  1  ID requests to issue an instruction that writes rd.
- issue_rd_i  in  AW  destination register of the issuing instruction.
- issue_ready_o  out  1  issue accepted this cycle.
- flush_i  in  1  pipeline refresh; clears all busy bits.

Behaviour:
- Reset (rst_i high at clock edge): all NREG data registers and all busy bits go to 0. Consequence: rdata_o = 0, rbusy_o = 0 and issue_ready_o = 1 from the first cycle after reset. Reset has priority over every other input. An issue or write in the reset cycle is discarded.
- Register 0: reads return 0, writes are ignored, the busy bit is never set, and rbusy_o is never asserted for address 0.
- Write: on the rising edge with we_i[w]=1 and waddr_i[w]!=0, reg[waddr] <= wdata. If two ports write the same address in the same cycle, port NWR-1 wins the data.
- Write completion: any enabled write to address a clears busy[a] at the same edge, unless the set rule below overrides it.
- Read: rdata_o[p] = reg[raddr_i[p]], combinational, zero-latency. Bypass behaviour is given under Optional Feature.
- Issue handshake:
  - issue_ready_o = !issue_valid_i | (issue_rd_i==0) | !busy_eff[issue_rd_i].
  - busy_eff[a] = busy[a] & !(same-cycle write to a, bypass build only).
  - Issue is accepted when issue_valid_i & issue_ready_o. On accept with rd!=0, busy[rd] <= 1 at the edge.
  - Same-cycle write and accepted issue to the same rd: set wins, and busy stays 1 for the new producer.
  - Not accepted means WAW stall: the busy bit is unchanged, and ID holds issue_valid_i and issue_rd_i stable.
- rbusy_o[p] = busy_eff[raddr_i[p]] & (raddr_i[p]!=0). Combinational, no dependence on issue_valid_i.
- Flush: flush_i=1 clears all busy bits at the edge. Register writes in the same cycle still commit. An accepted issue in the flush cycle is ignored; flush wins.
- Each busy bit tracks one outstanding producer, so at most one in-flight writer per register is allowed.
- Each register holds its value until overwritten.
- No wrap-around conditions: there are no counters.

Optional Feature:
- Macro: REGS_FILE_BYPASS_EN.
- Defined:
  - A same-cycle write forwards to matching read ports. Highest-index write port wins, x0 is excluded.
  - busy_eff masks the busy bit of the register being written, so rbusy_o drops in the writeback cycle. This saves one stall cycle per RAW hazard.
- Undefined:
  - Reads return the pre-edge register value.
  - rbusy_o stays asserted through the writeback cycle and deasserts on the following cycle.
  - issue_ready_o uses raw busy.

Decomposition:
- milano_pkg gains:
  - REG_NUM = 32.
  - REG_AW = 5.
  - typedef reg_addr_t = logic [REG_AW-1:0].
  - typedef xlen_t = logic [31:0].
  - NRD and NWR defaults are not defined here.
- One sub-module, regs_sb: holds the NREG-bit busy vector with its set/clear/flush logic, and produces the busy_eff and issue_ready signals.
- The data array and read muxes stay in regs_file_sb.

Test Plan:
- Reset then read: rst_i=1 for 2 cycles, then raddr_i={5,0} → rdata_o={0,0}, rbusy_o=0, issue_ready_o=1.
- Write then read: we=1, waddr=3, wdata=0xDEADBEEF; next cycle read r3 → 0xDEADBEEF.
- Write x0: write 0x1234 to r0, then read r0 → 0. Issue rd=0 → busy never set and ready stays 1.
- RAW hazard: issue rd=7, then read r7 → rbusy_o=1. Write r7=0x55:
  - bypass build: rbusy_o=0 and rdata=0x55 in the write cycle.
  - non-bypass build: rbusy_o=1 in the write cycle, then 0 with data 0x55 the next cycle.
- WAW stall and flush: issue rd=9, then issue rd=9 again → issue_ready_o=0. Assert flush_i → next cycle issue rd=9 has ready=1 and rbusy for r9 = 0.
- Collisions (NWR=2): both ports write r4 with 0xA/0xB → r4=0xB. Issue rd=4 in the same cycle as its write (bypass build) → accepted, and r4 busy=1 afterwards.
